// File: rtl/input_ctrl_pkg.sv
// Flit format, virtual-channel sizing and e-cube routing shared by the router input controller.
// The macros are the single source of the link widths and flit-type codes; the package mirrors them as typed constants.
`ifndef INPUT_CTRL_DEFINES
`define INPUT_CTRL_DEFINES
`define DATA_WIDTH    16
`define VCH_WIDTH_NUM 1
`define VCH_NUM       (2**`VCH_WIDTH_NUM)
`define PORT_NUM      5
`define FLIT_BODY     2'b00
`define FLIT_HEAD     2'b01
`define FLIT_TAIL     2'b10
`define FLIT_SINGLE   2'b11
`endif

package input_ctrl_pkg;

    localparam int DATA_WIDTH = `DATA_WIDTH;
    localparam int VCH_W      = `VCH_WIDTH_NUM;
    localparam int VCH_NUM    = `VCH_NUM;
    localparam int PORT_NUM   = `PORT_NUM;

    typedef enum logic [1:0] {
        TYPE_BODY   = `FLIT_BODY,
        TYPE_HEAD   = `FLIT_HEAD,
        TYPE_TAIL   = `FLIT_TAIL,
        TYPE_SINGLE = `FLIT_SINGLE
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND
    } state_e;

    function automatic flit_type_e flit_type(input logic [DATA_WIDTH-1:0] flit);
        return flit_type_e'(flit[DATA_WIDTH-1 -: 2]);
    endfunction

    function automatic logic [3:0] flit_dest(input logic [DATA_WIDTH-1:0] flit);
        return flit[DATA_WIDTH-3 -: 4];
    endfunction

    // Head and single codes share a set low type bit: the flit opens a packet.
    function automatic logic starts_packet(input logic [DATA_WIDTH-1:0] flit);
        return flit[DATA_WIDTH-2];
    endfunction

    // Dimension-ordered routing: correct the lowest differing address bit first.
    function automatic logic [PORT_NUM-1:0] ecube_route(input logic [3:0] dest,
                                                        input logic [3:0] node_id);
        logic [3:0] diff;
        diff = dest ^ node_id;
        ecube_route = '0;
        if (diff == 4'd0) begin
            ecube_route[PORT_NUM-1] = 1'b1;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (diff[i]) begin
                    ecube_route    = '0;
                    ecube_route[i] = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit buffer: circular storage with occupancy count.
// A write to a full buffer is accepted only when a pop frees a slot in the same cycle.
module vc_fifo
    import input_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             accept;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == FULL_COUNT);
    assign do_pop = pop && !empty;
    assign accept = write && (!full || do_pop);
    assign head   = mem[rd_ptr];

    // NOTE: the data array has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly PTR_W bits wide, so the increment wraps at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_ctrl.sv
// Router input port: per-VC flit buffers, round-robin packet selection, e-cube route
// request and wormhole forwarding to the crossbar, with registered credit return.
module input_ctrl
    import input_ctrl_pkg::*;
#(
    parameter logic [3:0] NODE_ID    = 4'd0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [`DATA_WIDTH-1:0]    link_data,
    input  logic                      link_valid,
    input  logic [`VCH_WIDTH_NUM-1:0] link_vch,
    output logic                      credit_out,
    output logic [`VCH_WIDTH_NUM-1:0] credit_vch,
    output logic [`DATA_WIDTH-1:0]    idata,
    output logic                      ivalid,
    output logic [`VCH_WIDTH_NUM-1:0] ivch,
    output logic [`PORT_NUM-1:0]      port,
    output logic                      req,
    input  logic [4:0]                grt,
    output logic                      overflow_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [VCH_NUM-1:0]    fifo_write;
    logic [VCH_NUM-1:0]    fifo_pop;
    logic [VCH_NUM-1:0]    fifo_empty;
    logic [VCH_NUM-1:0]    fifo_full;
    logic [DATA_WIDTH-1:0] fifo_head  [VCH_NUM];
    logic [CNT_W-1:0]      fifo_count [VCH_NUM];

    state_e                state;
    state_e                next_state;
    logic [VCH_W-1:0]      cur_vc;
    logic [VCH_W-1:0]      rr_ptr;
    logic [PORT_NUM-1:0]   cur_port;

    logic                  pick_valid;
    logic [VCH_W-1:0]      pick_vc;
    logic [VCH_W-1:0]      cand;
    logic [DATA_WIDTH-1:0] cur_head;
    logic                  granted;
    logic                  has_flit;
    logic                  xfer;

    for (genvar v = 0; v < VCH_NUM; v++) begin : g_vc
        assign fifo_write[v] = link_valid && (link_vch == VCH_W'(v));

        vc_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .write (fifo_write[v]),
            .wdata (link_data),
            .pop   (fifo_pop[v]),
            .head  (fifo_head[v]),
            .empty (fifo_empty[v]),
            .full  (fifo_full[v]),
            .count (fifo_count[v])
        );
    end

    // Scan from the VC after the last served one; iterating downward lets the nearest candidate win.
    always_comb begin
        pick_valid = 1'b0;
        pick_vc    = rr_ptr;
        cand       = rr_ptr;
        for (int k = VCH_NUM; k >= 1; k--) begin
            cand = rr_ptr + VCH_W'(k);
            if (!fifo_empty[cand] && starts_packet(fifo_head[cand])) begin
                pick_valid = 1'b1;
                pick_vc    = cand;
            end
        end
    end

    assign cur_head = fifo_head[cur_vc];
    assign granted  = |(grt & cur_port);
    assign has_flit = (fifo_count[cur_vc] != '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        req        = 1'b0;
        port       = '0;
        xfer       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                req  = 1'b1;
                port = cur_port;
                if (granted) begin
                    xfer       = has_flit;
                    next_state = (xfer && flit_type(cur_head) == TYPE_SINGLE) ? ST_IDLE : ST_SEND;
                end
            end
            ST_SEND: begin
                req  = 1'b1;
                port = cur_port;
                if (granted) begin
                    xfer = has_flit;
                    if (xfer && flit_type(cur_head) == TYPE_TAIL) begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign ivalid   = xfer;
    assign idata    = cur_head;
    assign ivch     = cur_vc;
    assign fifo_pop = xfer ? (VCH_NUM'(1) << cur_vc) : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cur_vc       <= '0;
            rr_ptr       <= '0;
            cur_port     <= '0;
            credit_out   <= 1'b0;
            credit_vch   <= '0;
            overflow_err <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && pick_valid) begin
                cur_vc   <= pick_vc;
                rr_ptr   <= pick_vc;
                cur_port <= ecube_route(flit_dest(fifo_head[pick_vc]), NODE_ID);
            end
            credit_out <= xfer;
            if (xfer) begin
                credit_vch <= cur_vc;
            end
            if (link_valid && fifo_full[link_vch] && !fifo_pop[link_vch]) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_input_ctrl.sv
// Directed bench for input_ctrl: a queue-based model checked every cycle plus literal expectations per scenario.
module tb_input_ctrl;
    import input_ctrl_pkg::*;

    localparam logic [3:0] NODE  = 4'd0;
    localparam int         DEPTH = 4;

    logic                  clk        = 1'b0;
    logic                  reset      = 1'b1;
    logic [DATA_WIDTH-1:0] link_data  = '0;
    logic                  link_valid = 1'b0;
    logic [VCH_W-1:0]      link_vch   = '0;
    logic [4:0]            grt        = '0;
    logic                  credit_out;
    logic [VCH_W-1:0]      credit_vch;
    logic [DATA_WIDTH-1:0] idata;
    logic                  ivalid;
    logic [VCH_W-1:0]      ivch;
    logic [PORT_NUM-1:0]   port;
    logic                  req;
    logic                  overflow_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    input_ctrl #(
        .NODE_ID    (NODE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .link_data    (link_data),
        .link_valid   (link_valid),
        .link_vch     (link_vch),
        .credit_out   (credit_out),
        .credit_vch   (credit_vch),
        .idata        (idata),
        .ivalid       (ivalid),
        .ivch         (ivch),
        .port         (port),
        .req          (req),
        .grt          (grt),
        .overflow_err (overflow_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_WIDTH-1:0] m_q [VCH_NUM][$];
    int                    m_phase;    // 0: no packet owned, 1: waiting for first grant, 2: mid-packet
    int                    m_cur;
    int                    m_last;
    logic [4:0]            m_port;
    bit                    m_credit;
    int                    m_credit_vc;
    bit                    m_ovf;

    function automatic logic [4:0] model_route(input logic [3:0] dest);
        logic [3:0] d;
        d = dest ^ NODE;
        if (d == 4'd0) return 5'b10000;
        for (int i = 0; i < 4; i++) begin
            if (d[i]) return 5'b00001 << i;
        end
        return 5'b00000;
    endfunction

    function automatic int ftype(input logic [DATA_WIDTH-1:0] f);
        return int'(f[DATA_WIDTH-1 -: 2]);
    endfunction

    always @(negedge clk) begin
        bit                    granted;
        bit                    xfer;
        int                    v;
        logic [DATA_WIDTH-1:0] f;
        f = '0;
        if (reset) begin
            foreach (m_q[i]) m_q[i].delete();
            m_phase  = 0;
            m_cur    = 0;
            m_last   = 0;
            m_port   = '0;
            m_credit = 0;
            m_credit_vc = 0;
            m_ovf    = 0;
            check("rst_req", 32'(req), 32'(0));
            check("rst_port", 32'(port), 32'(0));
            check("rst_ivalid", 32'(ivalid), 32'(0));
            check("rst_credit", 32'(credit_out), 32'(0));
            check("rst_credit_vch", 32'(credit_vch), 32'(0));
            check("rst_overflow", 32'(overflow_err), 32'(0));
        end else begin
            granted = (m_phase != 0) && ((grt & m_port) != 5'b0);
            xfer    = granted && (m_q[m_cur].size() > 0);
            if (xfer) f = m_q[m_cur][0];
            check("cmp_req", 32'(req), 32'(m_phase != 0));
            check("cmp_port", 32'(port), 32'(m_phase != 0 ? m_port : 5'b0));
            check("cmp_ivalid", 32'(ivalid), 32'(xfer));
            if (xfer) begin
                check("cmp_idata", 32'(idata), 32'(f));
                check("cmp_ivch", 32'(ivch), 32'(m_cur));
            end
            check("cmp_credit", 32'(credit_out), 32'(m_credit));
            if (m_credit) check("cmp_credit_vch", 32'(credit_vch), 32'(m_credit_vc));
            check("cmp_overflow", 32'(overflow_err), 32'(m_ovf));

            // advance to the state after the coming clock edge
            if (m_phase == 0) begin
                for (int k = 1; k <= VCH_NUM; k++) begin
                    v = (m_last + k) % VCH_NUM;
                    if (m_q[v].size() > 0 && (ftype(m_q[v][0]) == 1 || ftype(m_q[v][0]) == 3)) begin
                        m_cur   = v;
                        m_last  = v;
                        m_port  = model_route(m_q[v][0][DATA_WIDTH-3 -: 4]);
                        m_phase = 1;
                        break;
                    end
                end
            end else if (m_phase == 1) begin
                if (granted) m_phase = (xfer && ftype(f) == 3) ? 0 : 2;
            end else if (xfer && ftype(f) == 2) begin
                m_phase = 0;
            end
            m_credit = xfer;
            if (xfer) begin
                m_credit_vc = m_cur;
                void'(m_q[m_cur].pop_front());
            end
            if (link_valid) begin
                if (m_q[link_vch].size() < DEPTH) m_q[link_vch].push_back(link_data);
                else m_ovf = 1;
            end
        end
    end

    // delivered-flit log used by the literal scenario checks
    int                    vc_log[$];
    logic [DATA_WIDTH-1:0] data_log[$];
    always @(negedge clk) begin
        if (!reset && ivalid) begin
            vc_log.push_back(int'(ivch));
            data_log.push_back(idata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_WIDTH-1:0] mk(input logic [1:0] t, input logic [3:0] d,
                                                 input logic [9:0] p);
        return {t, d, p};
    endfunction

    task automatic put(input int vc, input logic [DATA_WIDTH-1:0] f);
        link_valid = 1'b1;
        link_vch   = VCH_W'(vc);
        link_data  = f;
        tick();
        link_valid = 1'b0;
    endtask

    task automatic wait_req(input string name, output bit seen);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 32'(0), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int first;
        int last;
        int cnt;
        bit req_after;
        int exp_order[7];

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_req", 32'(req), 32'(0));

        // single flit dest 0110 -> port 1
        tick();
        grt = 5'b00010;
        put(0, mk(2'b11, 4'b0110, 10'h011));
        wait_req("single", seen);
        if (seen) begin
            check("single_port", 32'(port), 32'(5'b00010));
            check("single_ivalid", 32'(ivalid), 32'(1));
            check("single_idata", 32'(idata), 32'(16'hD811));
        end
        @(negedge clk);
        check("single_credit", 32'(credit_out), 32'(1));
        check("single_credit_vch", 32'(credit_vch), 32'(0));
        check("single_req_drop", 32'(req), 32'(0));

        // destination equal to this node -> local port
        tick();
        grt = 5'b10000;
        put(0, mk(2'b11, 4'b0000, 10'h022));
        wait_req("local", seen);
        if (seen) begin
            check("local_port", 32'(port), 32'(5'b10000));
            check("local_ivalid", 32'(ivalid), 32'(1));
        end

        // four-flit packet held off by a low grant
        tick();
        grt = 5'b00000;
        put(0, mk(2'b01, 4'b0001, 10'h101));
        put(0, mk(2'b00, 4'b0000, 10'h102));
        put(0, mk(2'b00, 4'b0000, 10'h103));
        put(0, mk(2'b10, 4'b0000, 10'h104));
        repeat (3) begin
            @(negedge clk);
            check("wh_req_hold", 32'(req), 32'(1));
            check("wh_port_hold", 32'(port), 32'(5'b00001));
            check("wh_no_valid", 32'(ivalid), 32'(0));
        end
        tick();
        grt = 5'b00001;
        first = -1; last = -1; cnt = 0; req_after = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ivalid) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
            if (first >= 0 && i == first + 4) req_after = req;
        end
        check("wh_pulses", 32'(cnt), 32'(4));
        check("wh_consecutive", 32'(last - first), 32'(3));
        check("wh_req_after_tail", 32'(req_after), 32'(0));

        // two VCs with queued packets are served alternately
        tick();
        grt = 5'b11111;
        vc_log.delete();
        put(0, mk(2'b01, 4'b1000, 10'h201));
        put(0, mk(2'b10, 4'b0000, 10'h202));
        put(1, mk(2'b01, 4'b0100, 10'h301));
        put(1, mk(2'b00, 4'b0000, 10'h302));
        put(1, mk(2'b10, 4'b0000, 10'h303));
        put(0, mk(2'b11, 4'b0010, 10'h203));
        put(1, mk(2'b11, 4'b0001, 10'h304));
        repeat (12) @(negedge clk);
        exp_order = '{0, 0, 1, 1, 1, 0, 1};
        check("rr_count", 32'(vc_log.size()), 32'(7));
        for (int i = 0; i < 7; i++) begin
            if (i < vc_log.size()) check("rr_order", 32'(vc_log[i]), 32'(exp_order[i]));
        end

        // overflow on VC1 with no grant
        tick();
        grt = 5'b00000;
        vc_log.delete();
        data_log.delete();
        put(1, mk(2'b01, 4'b0010, 10'h001));
        put(1, mk(2'b00, 4'b0000, 10'h002));
        put(1, mk(2'b00, 4'b0000, 10'h003));
        put(1, mk(2'b10, 4'b0000, 10'h004));
        @(negedge clk);
        check("ovf_before", 32'(overflow_err), 32'(0));
        tick();
        put(1, mk(2'b00, 4'b0000, 10'h3FF));
        @(negedge clk);
        check("ovf_set", 32'(overflow_err), 32'(1));
        tick();
        grt = 5'b11111;
        repeat (10) @(negedge clk);
        check("ovf_delivered", 32'(data_log.size()), 32'(DEPTH));
        if (data_log.size() == DEPTH) check("ovf_last_is_tail", 32'(data_log[DEPTH-1]), 32'(16'h8004));
        check("ovf_sticky", 32'(overflow_err), 32'(1));

        // reset in the middle of a packet
        tick();
        grt = 5'b11111;
        put(0, mk(2'b01, 4'b0001, 10'h0A1));
        put(0, mk(2'b00, 4'b0000, 10'h0A2));
        tick();
        tick();
        grt = 5'b00000;
        put(0, mk(2'b00, 4'b0000, 10'h0A3));
        put(0, mk(2'b11, 4'b1111, 10'h0A4));
        @(negedge clk);
        check("mid_send_req", 32'(req), 32'(1));
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_req", 32'(req), 32'(0));
        check("rst_mid_port", 32'(port), 32'(0));
        tick();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_discard_req", 32'(req), 32'(0));
            check("rst_discard_credit", 32'(credit_out), 32'(0));
        end
        tick();
        grt = 5'b00100;
        put(0, mk(2'b11, 4'b1100, 10'h0B1));
        wait_req("post_rst", seen);
        if (seen) begin
            check("post_rst_port", 32'(port), 32'(5'b00100));
            check("post_rst_ivalid", 32'(ivalid), 32'(1));
        end

        tick();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
